// File: rtl/multiplier_4bit_if.sv
// Start/busy/done handshake and operand/result bus between the ALU controller
// and the sequential 4x4 multiplier.
interface multiplier_4bit_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] product_low;
    logic [3:0] product_high;
    logic       busy;
    logic       done;

    modport master (
        output start, A, B,
        input  product_low, product_high, busy, done
    );

    modport slave (
        input  start, A, B,
        output product_low, product_high, busy, done
    );
endinterface

// File: rtl/multiplier_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier: one partial product per clock,
// result published as two registered nibbles with a one-cycle done pulse.
module multiplier_4bit (
    input  logic              clk,
    input  logic              rst_n,
    multiplier_4bit_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] mcand;
    logic [3:0] mplier;
    logic [7:0] acc;
    logic [1:0] cnt;

    logic [7:0] acc_nxt;
    logic       accept;
    logic       last_iter;

    logic [3:0] prod_lo_q;
    logic [3:0] prod_hi_q;
    logic       done_q;

    // One shift-and-add step; 4x4 products fit in 8 bits so the add never overflows.
    function automatic logic [7:0] add_partial(
        input logic [7:0] acc_in,
        input logic [7:0] addend,
        input logic       use_it
    );
        return use_it ? (acc_in + addend) : acc_in;
    endfunction

    assign acc_nxt = add_partial(acc, mcand, mplier[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 2'd3) begin
                    last_iter = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= {4'b0000, bus.A};
            mplier <= bus.B;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_nxt;
            mcand  <= {mcand[6:0], 1'b0};
            mplier <= {1'b0, mplier[3:1]};
            cnt    <= cnt + 2'd1;
        end
    end

    // Outputs change only on completion, so intermediate sums are never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_lo_q <= '0;
            prod_hi_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_iter;
            if (last_iter) begin
                prod_lo_q <= acc_nxt[3:0];
                prod_hi_q <= acc_nxt[7:4];
            end
        end
    end

    assign bus.product_low  = prod_lo_q;
    assign bus.product_high = prod_hi_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state == RUN);

endmodule

// File: tb/tb_multiplier_4bit.sv
// Directed bench for multiplier_4bit: handshake timing, hand-computed products,
// ignored start, mid-operation reset, back-to-back starts and a full operand sweep.
module tb_multiplier_4bit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    logic [7:0] last_prod;

    multiplier_4bit_if bus ();

    multiplier_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] prod();
        return {bus.product_high, bus.product_low};
    endfunction

    // Launch one multiply and follow it edge by edge to the done pulse.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) begin
                check({tag, " busy"}, {7'd0, bus.busy}, 8'd1);
                check({tag, " done early"}, {7'd0, bus.done}, 8'd0);
                check({tag, " hold"}, prod(), last_prod);
            end
            @(posedge clk);
            #1;
        end
        check({tag, " done"}, {7'd0, bus.done}, 8'd1);
        check({tag, " busy end"}, {7'd0, bus.busy}, 8'd0);
        check({tag, " product"}, prod(), exp);
        last_prod = exp;
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, {7'd0, bus.done}, 8'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        last_prod = 8'h00;
        bus.start = 1'b0;
        bus.A     = 4'd0;
        bus.B     = 4'd0;
        rst_n     = 1'b0;
        #1;
        check("reset product", prod(), 8'h00);
        check("reset busy", {7'd0, bus.busy}, 8'd0);
        check("reset done", {7'd0, bus.done}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0010, 4'b0011, 8'h06, "2x3");
        run_op(4'b0101, 4'b0101, 8'h19, "5x5");
        run_op(4'b0110, 4'b0011, 8'h12, "6x3");
        run_op(4'b1001, 4'b0100, 8'h24, "9x4");
        run_op(4'b1111, 4'b1111, 8'hE1, "15x15");
        run_op(4'b0000, 4'b1111, 8'h00, "0x15");

        // Second start while busy must be ignored.
        @(negedge clk);
        bus.A = 4'd15; bus.B = 4'd15; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.A = 4'd2; bus.B = 4'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ignore done", {7'd0, bus.done}, 8'd1);
        check("ignore product", prod(), 8'hE1);
        last_prod = 8'hE1;
        @(posedge clk); #1;
        check("ignore no restart", {7'd0, bus.busy}, 8'd0);
        check("ignore done pulse", {7'd0, bus.done}, 8'd0);

        // Reset two cycles into a 5x5 aborts it immediately.
        @(negedge clk);
        bus.A = 4'd5; bus.B = 4'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort product", prod(), 8'h00);
        check("abort busy", {7'd0, bus.busy}, 8'd0);
        check("abort done", {7'd0, bus.done}, 8'd0);
        last_prod = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort no done", {7'd0, bus.done}, 8'd0);
        end
        run_op(4'b0110, 4'b0011, 8'h12, "post-reset 6x3");

        // Start held high: a result every 5th edge.
        @(negedge clk);
        bus.A = 4'b1001; bus.B = 4'b0100; bus.start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            check("stream done", {7'd0, bus.done}, (c % 5 == 4) ? 8'd1 : 8'd0);
            if (c >= 4)
                check("stream product", prod(), 8'h24);
        end
        bus.start = 1'b0;
        last_prod = 8'h24;
        @(posedge clk); #1;
        check("stream idle", {7'd0, bus.busy}, 8'd0);

        // Every operand pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [7:0] exp;
                exp = 8'(a * b);
                @(negedge clk);
                bus.A = 4'(a); bus.B = 4'(b); bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                check("sweep done", {7'd0, bus.done}, 8'd1);
                check($sformatf("sweep %0dx%0d", a, b), prod(), exp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multiplier_4bit.md
Name: multiplier_4bit

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier; one partial product per clock.
- Produces an 8-bit product, presented as two 4-bit nibbles: product_low = bits [3:0], product_high = bits [7:4].
- Arithmetic sub-block of the ALU datapath. Uses a start/busy/done handshake so the ALU controller can sequence it.

Parameters:
- None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to multiply the current A and B; sampled on the rising clk edge.
- A  input  4  unsigned multiplicand.
- B  input  4  unsigned multiplier.
- product_low  output  4  product bits [3:0]; registered.
- product_high  output  4  product bits [7:4]; registered.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse when a new product is valid.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, independent of clk):
  - product_low, product_high, busy and done all go to 0.
  - Internal state returns to IDLE; the accumulator, operand registers and counter clear.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE and RUN.
- IDLE, start=1 at edge E0:
  - A latches into an 8-bit multiplicand register (zero-extended). B latches into a 4-bit multiplier register.
  - The 8-bit accumulator clears, the 2-bit iteration counter clears, and the state becomes RUN.
  - busy=1 from E0 onward.
- RUN, at each of edges E1..E4:
  - If the multiplier register LSB is 1, accumulator += multiplicand register (8-bit add; no overflow is possible).
  - The multiplicand shifts left by 1, the multiplier shifts right by 1, and the counter increments.
- At E4 (the 4th iteration):
  - The final accumulator value (including the E4 add) loads into the outputs: product_low = acc[3:0], product_high = acc[7:4].
  - done=1 for exactly the cycle after E4; busy returns to 0; the state returns to IDLE.
- Latency: 4 clocks from the capturing edge to a valid product. Throughput: one result per 5 cycles when start is held high.
- Operand handling:
  - A and B may change freely after E0 without affecting the running operation.
  - start while busy=1 is ignored; no queuing.
  - start during the done cycle is accepted (the block is IDLE then) and begins a new operation at that edge.
- product_low and product_high hold the last completed result until the next completion or reset. They never show intermediate accumulator values.
- Result is exactly {product_high, product_low} = A*B, unsigned, for all 256 operand pairs.
- Zero operands still take the full 4 cycles; the result is 0.

Test Plan:
- Reset, then A=0010, B=0011, pulse start -> after 4 clocks done=1 for one cycle, product_low=0110, product_high=0000; busy high for exactly 4 cycles.
- A=0101, B=0101 -> low=1001, high=0001. A=0110, B=0011 -> low=0010, high=0001. A=1001, B=0100 -> low=0100, high=0010.
- A=1111, B=1111 -> low=0001, high=1110. A=0000, B=1111 -> low=0000, high=0000.
- Start 15x15; during busy change A/B to 2x3 and pulse start again -> result 0001/1110; the second start is ignored.
- Start 5x5; assert rst_n=0 two cycles later -> outputs immediately 0, busy=0, no done. After release, 6x3 completes normally with 0010/0001.
- Hold start=1 continuously with A=1001, B=0100 -> done every 5th cycle, product stable at 0100/0010. Exhaustive sweep of all 256 pairs matches A*B.
